// File: rtl/dio_pkg.sv
// Shared constants and FSM encoding for the two-requester shared-adder arbiter.
package dio_pkg;
   localparam int DEF_W = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      RESP = 2'd2
   } state_e;
endpackage

// File: rtl/add_arb_if.sv
// Request/operand/result bundle between the two requesters and add_arb.
interface add_arb_if
   import dio_pkg::*;
#(
   parameter int W = DEF_W
) ();
   logic         req0, req1;
   logic [W-1:0] a0, b0, a1, b1;
   logic         gnt0, gnt1;
   logic         done0, done1;
   logic [W:0]   sum;
   logic         busy;

   modport master (
      output req0, a0, b0, req1, a1, b1,
      input  gnt0, gnt1, done0, done1, sum, busy
   );

   modport slave (
      input  req0, a0, b0, req1, a1, b1,
      output gnt0, gnt1, done0, done1, sum, busy
   );
endinterface

// File: rtl/add_stage.sv
// Registered adder: operands captured on load_i, W+1-bit sum registered on calc_i.
module add_stage
   import dio_pkg::*;
#(
   parameter int W = DEF_W
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         load_i,
   input  logic [W-1:0] a_i,
   input  logic [W-1:0] b_i,
   input  logic         calc_i,
   output logic [W:0]   sum_o
);
   logic [W-1:0] op_a_q, op_b_q;
   logic [W:0]   sum_q;

   always_ff @(posedge clk) begin
      if (rst) begin
         op_a_q <= '0;
         op_b_q <= '0;
         sum_q  <= '0;
      end else begin
         if (load_i) begin
            op_a_q <= a_i;
            op_b_q <= b_i;
         end
         // Zero-extend both operands so the carry lands in the MSB.
         if (calc_i) sum_q <= {1'b0, op_a_q} + {1'b0, op_b_q};
      end
   end

   assign sum_o = sum_q;
endmodule

// File: rtl/add_arb.sv
// Round-robin arbiter sharing one registered adder between two requesters (IDLE/CALC/RESP).
module add_arb
   import dio_pkg::*;
#(
   parameter int W = DEF_W
) (
   input logic      clk,
   input logic      rst,
   add_arb_if.slave bus
);
   state_e       state_q, state_d;
   logic         ptr_q, ptr_d;
   logic         owner_q, owner_d;
   logic         gnt0_q, gnt0_d, gnt1_q, gnt1_d;
   logic         done0_q, done0_d, done1_q, done1_d;
   logic         busy_q, busy_d;
   logic [W-1:0] a_sel, b_sel;
   logic [W:0]   sum_w;

   always_comb begin
      state_d = state_q;
      ptr_d   = ptr_q;
      owner_d = owner_q;
      gnt0_d  = 1'b0;
      gnt1_d  = 1'b0;
      done0_d = 1'b0;
      done1_d = 1'b0;
      case (state_q)
         IDLE: begin
            // ptr_q=0 favours requester 0; each grant hands priority to the other side.
            if (bus.req0 && (!bus.req1 || !ptr_q)) begin
               state_d = CALC;
               gnt0_d  = 1'b1;
               owner_d = 1'b0;
               ptr_d   = 1'b1;
            end else if (bus.req1) begin
               state_d = CALC;
               gnt1_d  = 1'b1;
               owner_d = 1'b1;
               ptr_d   = 1'b0;
            end
         end
         CALC: begin
            state_d = RESP;
            done0_d = !owner_q;
            done1_d = owner_q;
         end
         RESP:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
      busy_d = (state_d != IDLE);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         ptr_q   <= 1'b0;
         owner_q <= 1'b0;
         gnt0_q  <= 1'b0;
         gnt1_q  <= 1'b0;
         done0_q <= 1'b0;
         done1_q <= 1'b0;
         busy_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         ptr_q   <= ptr_d;
         owner_q <= owner_d;
         gnt0_q  <= gnt0_d;
         gnt1_q  <= gnt1_d;
         done0_q <= done0_d;
         done1_q <= done1_d;
         busy_q  <= busy_d;
      end
   end

   assign a_sel = gnt1_d ? bus.a1 : bus.a0;
   assign b_sel = gnt1_d ? bus.b1 : bus.b0;

   add_stage #(.W(W)) u_add (
      .clk    (clk),
      .rst    (rst),
      .load_i (gnt0_d | gnt1_d),
      .a_i    (a_sel),
      .b_i    (b_sel),
      .calc_i (state_q == CALC),
      .sum_o  (sum_w)
   );

   assign bus.gnt0  = gnt0_q;
   assign bus.gnt1  = gnt1_q;
   assign bus.done0 = done0_q;
   assign bus.done1 = done1_q;
   assign bus.busy  = busy_q;
   assign bus.sum   = sum_w;
endmodule

// File: tb/tb_add_arb.sv
// Scoreboard bench for add_arb: transaction-level model predicts grants/results, monitor checks them.
module tb_add_arb;
   localparam int TW = 8;

   typedef struct {
      bit          who;
      int          e;
      logic [TW:0] s;
   } exp_t;

   logic clk;
   logic rst;
   add_arb_if #(.W(TW)) bus ();

   add_arb #(.W(TW)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int   n_cmp = 0;
   int   n_bad = 0;
   int   edge_n = 0;
   exp_t gq[$];
   exp_t dq[$];
   // Transaction-level model state: favoured requester, earliest edge the adder is free, last grant edge.
   bit   ptr_m = 1'b0;
   int   next_ok = 1;
   int   last_g = -100;

   task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, got, exp, edge_n);
      end
   endtask

   task automatic model(input bit r0, input logic [TW-1:0] x0, input logic [TW-1:0] y0,
                        input bit r1, input logic [TW-1:0] x1, input logic [TW-1:0] y1,
                        input bit rs);
      int   e;
      bit   w;
      exp_t t;
      e = edge_n + 1;
      if (rs) begin
         ptr_m = 1'b0;
         while (gq.size() > 0 && gq[gq.size()-1].e >= e) void'(gq.pop_back());
         while (dq.size() > 0 && dq[dq.size()-1].e >= e) void'(dq.pop_back());
         if (last_g + 1 >= e) last_g = -100;
         next_ok = e + 1;
      end else if (e >= next_ok && (r0 || r1)) begin
         w     = (r0 && r1) ? ptr_m : r1;
         ptr_m = !w;
         t.who = w;
         t.e   = e;
         t.s   = '0;
         gq.push_back(t);
         t.e   = e + 1;
         t.s   = w ? (TW+1)'(x1) + (TW+1)'(y1) : (TW+1)'(x0) + (TW+1)'(y0);
         dq.push_back(t);
         last_g  = e;
         next_ok = e + 3;
      end
   endtask

   task automatic step(input bit r0, input logic [TW-1:0] x0, input logic [TW-1:0] y0,
                       input bit r1, input logic [TW-1:0] x1, input logic [TW-1:0] y1,
                       input bit rs);
      @(negedge clk);
      bus.req0 = r0; bus.a0 = x0; bus.b0 = y0;
      bus.req1 = r1; bus.a1 = x1; bus.b1 = y1;
      rst = rs;
      model(r0, x0, y0, r1, x1, y1, rs);
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0);
   endtask

   // Monitor: samples just after each rising edge and consumes the expected queues.
   always begin
      exp_t t;
      bit   exp_busy;
      @(posedge clk);
      edge_n++;
      #1;
      chk("gnt_excl", bus.gnt0 & bus.gnt1, 0);
      chk("done_excl", bus.done0 & bus.done1, 0);
      chk("gnt_done_same_cycle", (bus.gnt0 | bus.gnt1) & (bus.done0 | bus.done1), 0);
      exp_busy = (edge_n >= last_g) && (edge_n <= last_g + 1);
      chk("busy", bus.busy, exp_busy);
      while (gq.size() > 0 && gq[0].e < edge_n) begin
         t = gq.pop_front();
         chk("gnt_missing_at_edge", edge_n, t.e);
      end
      while (dq.size() > 0 && dq[0].e < edge_n) begin
         t = dq.pop_front();
         chk("done_missing_at_edge", edge_n, t.e);
      end
      if (bus.gnt0 | bus.gnt1) begin
         if (gq.size() == 0) chk("gnt_unexpected", 1, 0);
         else begin
            t = gq.pop_front();
            chk("gnt_edge", edge_n, t.e);
            chk("gnt_who", bus.gnt1, t.who);
         end
      end
      if (bus.done0 | bus.done1) begin
         if (dq.size() == 0) chk("done_unexpected", 1, 0);
         else begin
            t = dq.pop_front();
            chk("done_edge", edge_n, t.e);
            chk("done_who", bus.done1, t.who);
            chk("sum", bus.sum, t.s);
         end
      end
   end

   initial begin
      rst = 1'b1;
      bus.req0 = 0; bus.a0 = 0; bus.b0 = 0;
      bus.req1 = 0; bus.a1 = 0; bus.b1 = 0;
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);

      // Reset state, then first edge after reset serves requester 0: 3+4=7.
      step(1, 3, 4, 0, 0, 0, 0);
      chk("rst_gnt0", bus.gnt0, 0);
      chk("rst_gnt1", bus.gnt1, 0);
      chk("rst_done0", bus.done0, 0);
      chk("rst_done1", bus.done1, 0);
      chk("rst_busy", bus.busy, 0);
      chk("rst_sum", bus.sum, 0);
      idle(5);

      // Both held high from a fresh reset: grants alternate 0,1,... with sums 15,21.
      step(0, 0, 0, 0, 0, 0, 1);
      for (int i = 0; i < 12; i++) step(1, 10, 5, 1, 20, 1, 0);
      idle(4);

      // All-ones boundary on requester 1.
      step(0, 0, 0, 1, 255, 255, 0);
      idle(4);

      // Operand changes after the grant are ignored.
      step(1, 1, 1, 0, 0, 0, 0);
      step(0, 100, 1, 0, 0, 0, 0);
      step(0, 100, 1, 0, 0, 0, 0);
      idle(3);

      // Reset during CALC aborts the operation and restores ptr=0.
      step(0, 0, 0, 1, 7, 7, 0);
      idle(3);
      step(1, 5, 6, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 0);
      chk("abort_sum", bus.sum, 0);
      chk("abort_busy", bus.busy, 0);
      chk("abort_done0", bus.done0, 0);
      step(1, 2, 2, 1, 9, 9, 0);
      idle(4);

      // req1 raised during RESP of a requester-0 operation.
      step(1, 2, 3, 0, 0, 0, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      step(0, 0, 0, 1, 4, 4, 0);
      step(0, 0, 0, 1, 4, 4, 0);
      step(0, 0, 0, 0, 0, 0, 0);
      idle(4);

      // Randomized traffic with occasional resets.
      for (int i = 0; i < 400; i++) begin
         logic [TW-1:0] x0, y0, x1, y1;
         x0 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         y0 = 8'($urandom_range(0, 255));
         x1 = 8'($urandom_range(0, 255));
         y1 = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 255));
         step(1'($urandom_range(0, 1)), x0, y0, 1'($urandom_range(0, 1)), x1, y1,
              $urandom_range(0, 39) == 0);
      end
      idle(6);

      chk("gnt_queue_drained", gq.size(), 0);
      chk("done_queue_drained", dq.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule

// File: doc/add_arb.md
ADD_ARB -- requirements
Module: add_arb

Interface
REQ-001 Parameter W, default 8, operand width in bits.
REQ-002 clk  input  1  system clock; all state updates on its rising edge.
REQ-003 rst  input  1  reset; synchronous and active-high.
REQ-004 req0  input  1  requester 0 request, level.
REQ-005 a0  input  W  requester 0 operand A.
REQ-006 b0  input  W  requester 0 operand B.
REQ-007 req1  input  1  requester 1 request, level.
REQ-008 a1  input  W  requester 1 operand A.
REQ-009 b1  input  W  requester 1 operand B.
REQ-010 gnt0  output  1  one-cycle grant pulse for requester 0; operands are captured on this grant.
REQ-011 gnt1  output  1  one-cycle grant pulse for requester 1; operands are captured on this grant.
REQ-012 done0  output  1  one-cycle result-valid pulse for requester 0.
REQ-013 done1  output  1  one-cycle result-valid pulse for requester 1.
REQ-014 sum  output  W+1  result of the last completed operation; held until the next completion.
REQ-015 busy  output  1  high in every state other than IDLE.

Function
REQ-016 The block SHALL share a single W-bit adder between two requesters using a three-state FSM: IDLE, CALC, RESP.
REQ-017 IDLE: req0/req1 SHALL be sampled only in IDLE; with no request, the FSM SHALL stay in IDLE.
REQ-018 IDLE with exactly one request: at the next edge the FSM SHALL enter CALC, the winner's gnt SHALL go high for exactly that cycle, and the winner's a/b SHALL be latched into internal operand registers.
REQ-019 IDLE with both requests: the winner SHALL be the requester selected by the round-robin pointer (ptr=0 favours requester 0).
REQ-020 The pointer SHALL update on every grant to favour the non-granted requester, regardless of whether the other requester was requesting.
REQ-021 CALC: at the next edge, sum SHALL load opA+opB zero-extended to W+1 bits (no overflow or truncation), and the FSM SHALL enter RESP.
REQ-022 RESP: the granted requester's done SHALL be high for exactly this cycle, with sum valid; at the next edge the FSM SHALL return to IDLE.
REQ-023 Latency: a request sampled at edge E0 SHALL produce gnt during E0..E1 and done during E1..E2, giving a minimum issue interval of 3 cycles.
REQ-024 Handshake: a requester SHALL deassert req before edge E2 after its grant; a req still high when IDLE is re-entered SHALL be treated as a new request.
REQ-025 Operand changes after the grant cycle SHALL NOT affect the result.
REQ-026 gnt0/gnt1 SHALL never be high in the same cycle; likewise done0/done1.
REQ-027 Requests arriving during CALC or RESP SHALL be ignored until IDLE; no request SHALL be queued or lost while it is held high.
REQ-028 Boundary: all-ones operands (255+255 at W=8) SHALL give sum=510, with the MSB set.

Reset
REQ-029 While rst=1 at an edge: state=IDLE, ptr=0, gnt0=gnt1=0, done0=done1=0, busy=0, sum=0, operand registers=0.
REQ-030 rst asserted mid-operation (CALC or RESP) SHALL abort the operation without producing any done pulse, and sum SHALL become 0.
REQ-031 The first edge with rst=0 SHALL evaluate requests normally from IDLE.

Structure
REQ-032 FSM state encodings (IDLE=2'd0, CALC=2'd1, RESP=2'd2) and the default width constant SHALL reside in the shared package dio_pkg.
REQ-033 The registered adder stage (operand registers plus W+1-bit sum register) SHALL be the single sub-module add_stage; add_arb SHALL contain the FSM, pointer and handshake logic.
REQ-034 All outputs SHALL be registered; there SHALL be no combinational path from inputs to outputs.

Verification
REQ-035 Bench SHALL cover: reset, then req0=1 with a0=3, b0=4 -> gnt0 pulse on cycle 1, done0 on cycle 2, sum=7; gnt1/done1 stay 0.
REQ-036 Bench SHALL cover: req0 and req1 both held high with a0=10, b0=5, a1=20, b1=1 -> grants alternate 0,1,0,1 every 3 cycles; sums alternate 15, 21.
REQ-037 Bench SHALL cover: W=8, a1=255, b1=255, req1 pulse -> sum=9'd510, done1=1 for one cycle.
REQ-038 Bench SHALL cover: after gnt0, change a0 from 1 to 100 during CALC -> sum uses 1.
REQ-039 Bench SHALL cover: rst asserted during CALC -> no done pulse, sum=0, busy=0 on the next cycle, ptr=0.
REQ-040 Bench SHALL cover: req1 raised during RESP of a requester-0 operation -> gnt1 appears only after IDLE is re-entered, never in the same cycle as done0.
